// File: rtl/burst_mem_arbiter_if.sv
// rtl/burst_mem_arbiter_if.sv - master-channel signal bundle for the burst memory arbiter
interface burst_mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int LEN_W       = 4
);
    logic                          io_start;
    logic [NUM_MASTERS-1:0]        io_m_wr;
    logic [NUM_MASTERS-1:0]        io_m_rd;
    logic [NUM_MASTERS*ADDR_W-1:0] io_m_address;
    logic [NUM_MASTERS*LEN_W-1:0]  io_m_length;
    logic [NUM_MASTERS*DATA_W-1:0] io_m_wdata;
    logic [NUM_MASTERS-1:0]        io_m_grant;
    logic [NUM_MASTERS-1:0]        io_m_wready;
    logic [NUM_MASTERS-1:0]        io_m_rvalid;
    logic [DATA_W-1:0]             io_m_rdata;
    logic [NUM_MASTERS-1:0]        io_m_done;
    logic                          io_busy;

    modport master (
        output io_start, io_m_wr, io_m_rd, io_m_address, io_m_length, io_m_wdata,
        input  io_m_grant, io_m_wready, io_m_rvalid, io_m_rdata, io_m_done, io_busy
    );

    modport slave (
        input  io_start, io_m_wr, io_m_rd, io_m_address, io_m_length, io_m_wdata,
        output io_m_grant, io_m_wready, io_m_rvalid, io_m_rdata, io_m_done, io_busy
    );
endinterface

// File: rtl/burst_mem_arbiter.sv
// rtl/burst_mem_arbiter.sv - round-robin N-master burst arbiter onto an internal register memory
module burst_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int LEN_W       = 4
) (
    input  logic                clock,
    input  logic                reset,
    burst_mem_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [IDX_W:0]   NM   = (IDX_W+1)'(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       rr_ptr, owner, win_idx;
    logic [IDX_W:0]         cand;
    logic [ADDR_W-1:0]      cur_addr;
    logic [LEN_W-1:0]       len_q, beat_cnt;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [NUM_MASTERS-1:0] req, req_rot, owner_oh;
    logic                   win_found, take, beat;

    logic [ADDR_W-1:0]      addr_a  [NUM_MASTERS];
    logic [LEN_W-1:0]       len_a   [NUM_MASTERS];
    logic [DATA_W-1:0]      wdata_a [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_a[g]  = bus.io_m_address[g*ADDR_W +: ADDR_W];
        assign len_a[g]   = bus.io_m_length[g*LEN_W +: LEN_W];
        assign wdata_a[g] = bus.io_m_wdata[g*DATA_W +: DATA_W];
    end

    assign req     = bus.io_m_wr | bus.io_m_rd;
    // Rotate so bit 0 is the master at the round-robin pointer.
    assign req_rot = NUM_MASTERS'({req, req} >> rr_ptr);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                cand      = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                win_idx   = (cand >= NM) ? IDX_W'(cand - NM) : IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        beat     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.io_start && win_found) begin
                    take = 1'b1;
                    if (len_a[win_idx] == '0)     state_nx = DONE;
                    else if (bus.io_m_wr[win_idx]) state_nx = WRITE;
                    else                           state_nx = READ;
                end
            end
            WRITE, READ: begin
                beat = 1'b1;
                if (beat_cnt == len_q - 1'b1) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            owner    <= '0;
            cur_addr <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (take) begin
                owner    <= win_idx;
                cur_addr <= addr_a[win_idx];
                len_q    <= len_a[win_idx];
                beat_cnt <= '0;
            end
            if (beat) begin
                cur_addr <= cur_addr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == WRITE) mem[cur_addr] <= wdata_a[owner];
            if (state == DONE)  rr_ptr <= (owner == LAST) ? '0 : owner + 1'b1;
        end
    end

    // beat_cnt is still 0 in the first burst cycle, and stays 0 in DONE for zero-length bursts.
    assign owner_oh        = NUM_MASTERS'(1) << owner;
    assign bus.io_busy     = (state != IDLE);
    assign bus.io_m_grant  = (state != IDLE && beat_cnt == '0) ? owner_oh : '0;
    assign bus.io_m_wready = (state == WRITE) ? owner_oh : '0;
    assign bus.io_m_rvalid = (state == READ)  ? owner_oh : '0;
    assign bus.io_m_done   = (state == DONE)  ? owner_oh : '0;
    assign bus.io_m_rdata  = (state == READ)  ? mem[cur_addr] : '0;
endmodule

// File: tb/tb_burst_mem_arbiter.sv
// tb/tb_burst_mem_arbiter.sv - randomized bench for burst_mem_arbiter against a transaction-level model
module tb_burst_mem_arbiter;
    localparam int N = 3, DW = 32, AW = 4, LW = 4, DEPTH = 16, BUDGET = 300;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    burst_mem_arbiter_if #(.NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();
    burst_mem_arbiter #(.NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_mem [DEPTH];
    int            exp_rr;
    int            t_addr [N];
    int            t_len  [N];
    logic [DW-1:0] wq     [N][$];

    int            grant_cyc [N];
    int            done_cyc  [N];
    int            wr_beats  [N];
    logic [DW-1:0] rq        [N][$];
    int            order     [$];
    int            proto_err;
    int            timed_out;

    int            exp_grant [N];
    int            exp_done  [N];
    logic [DW-1:0] exp_rq    [N][$];
    int            exp_order [$];

    task automatic setup(input int m, input int addr, input int len);
        t_addr[m] = addr;
        t_len[m]  = len;
        wq[m].delete();
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        exp_rr = 0;
    endtask

    // Transaction-level model: serve requesters one whole burst at a time in round-robin order.
    task automatic model_run(input logic [N-1:0] wr, input logic [N-1:0] rd, input int start_delay);
        bit pend [N];
        int cyc, w, left;
        exp_order.delete();
        left = 0;
        for (int m = 0; m < N; m++) begin
            exp_rq[m].delete();
            exp_grant[m] = -1;
            exp_done[m]  = -1;
            pend[m]      = wr[m] | rd[m];
            if (pend[m]) left++;
        end
        cyc = start_delay + 1;
        while (left > 0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && pend[(exp_rr + k) % N]) w = (exp_rr + k) % N;
            exp_order.push_back(w);
            exp_grant[w] = cyc;
            exp_done[w]  = cyc + t_len[w];
            for (int b = 0; b < t_len[w]; b++) begin
                if (wr[w]) exp_mem[(t_addr[w] + b) % DEPTH] = wq[w][b];
                else       exp_rq[w].push_back(exp_mem[(t_addr[w] + b) % DEPTH]);
            end
            exp_rr  = (w + 1) % N;
            pend[w] = 0;
            left--;
            cyc = exp_done[w] + 2;
        end
    endtask

    // Drives one round of requests from a negedge and records what the DUT does.
    task automatic run_txn(input logic [N-1:0] wr, input logic [N-1:0] rd, input int start_delay);
        logic [N-1:0] pend;
        int cyc;
        int wp [N];
        order.delete();
        proto_err = 0;
        timed_out = 0;
        for (int m = 0; m < N; m++) begin
            grant_cyc[m] = -1;
            done_cyc[m]  = -1;
            wr_beats[m]  = 0;
            wp[m]        = 0;
            rq[m].delete();
            bus.io_m_address[m*AW +: AW] = t_addr[m][AW-1:0];
            bus.io_m_length[m*LW +: LW]  = t_len[m][LW-1:0];
            bus.io_m_wdata[m*DW +: DW]   = '0;
        end
        bus.io_m_wr  = wr;
        bus.io_m_rd  = rd;
        bus.io_start = (start_delay == 0);
        pend = wr | rd;
        cyc  = 0;
        while ((pend != '0 || bus.io_busy) && cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
            if (cyc == start_delay) bus.io_start = 1'b1;
            if ($countones(bus.io_m_grant) > 1 || $countones(bus.io_m_done) > 1) proto_err++;
            if (bus.io_m_rvalid == '0 && bus.io_m_rdata != '0) proto_err++;
            for (int m = 0; m < N; m++) begin
                if (bus.io_m_grant[m]) begin
                    grant_cyc[m] = cyc;
                    order.push_back(m);
                    bus.io_m_wr[m] = 1'b0;
                    bus.io_m_rd[m] = 1'b0;
                end
                if (bus.io_m_done[m]) begin
                    done_cyc[m] = cyc;
                    pend[m]     = 1'b0;
                end
                if (bus.io_m_wready[m]) begin
                    wr_beats[m]++;
                    bus.io_m_wdata[m*DW +: DW] = (wp[m] < wq[m].size()) ? wq[m][wp[m]] : '0;
                    wp[m]++;
                end
                if (bus.io_m_rvalid[m]) rq[m].push_back(bus.io_m_rdata);
            end
        end
        if (cyc >= BUDGET) timed_out = 1;
        bus.io_m_wr  = '0;
        bus.io_m_rd  = '0;
        bus.io_start = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.io_start = 1'b1;
        bus.io_m_wr = '0; bus.io_m_rd = '0;
        bus.io_m_address = '0; bus.io_m_length = '0; bus.io_m_wdata = '0;
        model_clear();
        @(negedge clock);
        checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.io_busy); end
        checks++; if (bus.io_m_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", bus.io_m_grant); end
        checks++; if (bus.io_m_wready !== '0) begin errors++; $display("FAIL reset_wready: got %b expected 0", bus.io_m_wready); end
        checks++; if (bus.io_m_rvalid !== '0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.io_m_rvalid); end
        checks++; if (bus.io_m_done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.io_m_done); end
        checks++; if (bus.io_m_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.io_m_rdata); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write_read();
        setup(0, 7, 4);
        for (int i = 0; i < 4; i++) wq[0].push_back($urandom);
        run_txn(3'b001, 3'b000, 0);
        model_run(3'b001, 3'b000, 0);
        checks++; if (grant_cyc[0] !== 1) begin errors++; $display("FAIL wr_grant_cycle: got %0d expected 1", grant_cyc[0]); end
        checks++; if (done_cyc[0] !== 5) begin errors++; $display("FAIL wr_done_cycle: got %0d expected 5", done_cyc[0]); end
        checks++; if (wr_beats[0] !== 4) begin errors++; $display("FAIL wr_wready_beats: got %0d expected 4", wr_beats[0]); end
        setup(0, 7, 4);
        run_txn(3'b000, 3'b001, 0);
        model_run(3'b000, 3'b001, 0);
        checks++; if (done_cyc[0] !== exp_done[0]) begin errors++; $display("FAIL rd_done_cycle: got %0d expected %0d", done_cyc[0], exp_done[0]); end
        checks++; if (rq[0].size() !== 4) begin errors++; $display("FAIL rd_beats: got %0d expected 4", rq[0].size()); end
        for (int i = 0; i < 4 && i < rq[0].size(); i++) begin
            checks++;
            if (rq[0][i] !== exp_rq[0][i]) begin errors++; $display("FAIL rd_data[%0d]: got %h expected %h", i, rq[0][i], exp_rq[0][i]); end
        end
    endtask

    task automatic test_wrap();
        setup(1, 14, 4);
        for (int i = 1; i <= 4; i++) wq[1].push_back(DW'(i));
        run_txn(3'b010, 3'b000, 0);
        model_run(3'b010, 3'b000, 0);
        setup(1, 15, 2);
        run_txn(3'b000, 3'b010, 0);
        model_run(3'b000, 3'b010, 0);
        checks++; if (rq[1].size() !== 2) begin errors++; $display("FAIL wrap_beats: got %0d expected 2", rq[1].size()); end
        if (rq[1].size() == 2) begin
            checks++; if (rq[1][0] !== 32'd2) begin errors++; $display("FAIL wrap_mem15: got %h expected 2", rq[1][0]); end
            checks++; if (rq[1][1] !== 32'd3) begin errors++; $display("FAIL wrap_mem0: got %h expected 3", rq[1][1]); end
        end
        setup(1, 0, 2);
        run_txn(3'b000, 3'b010, 0);
        model_run(3'b000, 3'b010, 0);
        for (int i = 0; i < 2 && i < rq[1].size(); i++) begin
            checks++;
            if (rq[1][i] !== exp_rq[1][i]) begin errors++; $display("FAIL wrap_low[%0d]: got %h expected %h", i, rq[1][i], exp_rq[1][i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] masks [3];
        masks[0] = 3'b011; masks[1] = 3'b011; masks[2] = 3'b110;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int m = 0; m < N; m++) begin
                setup(m, $urandom_range(0, DEPTH-1), 2);
                wq[m].push_back($urandom); wq[m].push_back($urandom);
            end
            run_txn(masks[r], 3'b000, 0);
            model_run(masks[r], 3'b000, 0);
            checks++; if (order.size() !== exp_order.size()) begin errors++; $display("FAIL rr_count round %0d: got %0d expected %0d", r, order.size(), exp_order.size()); end
            for (int i = 0; i < exp_order.size() && i < order.size(); i++) begin
                checks++;
                if (order[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order round %0d slot %0d: got %0d expected %0d", r, i, order[i], exp_order[i]); end
            end
            for (int m = 0; m < N; m++) begin
                checks++;
                if (grant_cyc[m] !== exp_grant[m] || done_cyc[m] !== exp_done[m]) begin
                    errors++;
                    $display("FAIL rr_timing round %0d m%0d: got grant %0d done %0d expected grant %0d done %0d", r, m, grant_cyc[m], done_cyc[m], exp_grant[m], exp_done[m]);
                end
            end
        end
    endtask

    task automatic test_len0_start();
        setup(2, 5, 0);
        run_txn(3'b100, 3'b000, 0);
        model_run(3'b100, 3'b000, 0);
        checks++; if (grant_cyc[2] !== 1) begin errors++; $display("FAIL len0_grant: got %0d expected 1", grant_cyc[2]); end
        checks++; if (done_cyc[2] !== 1) begin errors++; $display("FAIL len0_done: got %0d expected 1", done_cyc[2]); end
        checks++; if (wr_beats[2] !== 0) begin errors++; $display("FAIL len0_wready: got %0d expected 0", wr_beats[2]); end
        setup(2, 5, 1);
        run_txn(3'b000, 3'b100, 0);
        model_run(3'b000, 3'b100, 0);
        checks++; if (rq[2].size() !== 1 || rq[2][0] !== exp_rq[2][0]) begin errors++; $display("FAIL len0_mem_unchanged: got %h expected %h", (rq[2].size() > 0) ? rq[2][0] : 'x, exp_rq[2][0]); end
        setup(0, 2, 1);
        wq[0].push_back($urandom);
        run_txn(3'b001, 3'b000, 5);
        model_run(3'b001, 3'b000, 5);
        checks++; if (grant_cyc[0] !== exp_grant[0]) begin errors++; $display("FAIL start_gate_grant: got %0d expected %0d", grant_cyc[0], exp_grant[0]); end
        checks++; if (done_cyc[0] !== exp_done[0]) begin errors++; $display("FAIL start_gate_done: got %0d expected %0d", done_cyc[0], exp_done[0]); end
    endtask

    task automatic test_wr_rd_both();
        setup(1, 3, 1);
        wq[1].push_back(32'h55);
        run_txn(3'b010, 3'b010, 0);
        model_run(3'b010, 3'b010, 0);
        checks++; if (rq[1].size() !== 0) begin errors++; $display("FAIL both_rvalid: got %0d beats expected 0", rq[1].size()); end
        checks++; if (wr_beats[1] !== 1) begin errors++; $display("FAIL both_wready: got %0d expected 1", wr_beats[1]); end
        setup(1, 3, 1);
        run_txn(3'b000, 3'b010, 0);
        model_run(3'b000, 3'b010, 0);
        checks++; if (rq[1].size() !== 1 || rq[1][0] !== 32'h55) begin errors++; $display("FAIL both_mem3: got %h expected 55", (rq[1].size() > 0) ? rq[1][0] : 'x); end
    endtask

    task automatic test_random();
        logic [N-1:0] wr, rd;
        for (int r = 0; r < 10; r++) begin
            wr = N'($urandom_range(0, 7));
            rd = N'($urandom_range(0, 7));
            if ((wr | rd) == '0) rd = 3'b001;
            for (int m = 0; m < N; m++) begin
                setup(m, $urandom_range(0, DEPTH-1), $urandom_range(0, 15));
                for (int i = 0; i < t_len[m]; i++) wq[m].push_back($urandom);
            end
            run_txn(wr, rd, 0);
            model_run(wr, rd, 0);
            checks++; if (timed_out !== 0 || proto_err !== 0) begin errors++; $display("FAIL rand_protocol round %0d: got timeout %0d proto %0d expected 0 0", r, timed_out, proto_err); end
            checks++; if (order != exp_order) begin errors++; $display("FAIL rand_order round %0d: got %p expected %p", r, order, exp_order); end
            for (int m = 0; m < N; m++) begin
                checks++;
                if (grant_cyc[m] !== exp_grant[m] || done_cyc[m] !== exp_done[m]) begin
                    errors++;
                    $display("FAIL rand_timing round %0d m%0d: got grant %0d done %0d expected grant %0d done %0d", r, m, grant_cyc[m], done_cyc[m], exp_grant[m], exp_done[m]);
                end
                checks++;
                if (rq[m] != exp_rq[m]) begin errors++; $display("FAIL rand_rdata round %0d m%0d: got %0d beats expected %0d beats", r, m, rq[m].size(), exp_rq[m].size()); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        setup(0, 8, 4);
        bus.io_m_address[0 +: AW] = 4'd8;
        bus.io_m_length[0 +: LW]  = 4'd4;
        bus.io_m_wdata[0 +: DW]   = $urandom;
        bus.io_start = 1'b1;
        bus.io_m_wr  = 3'b001;
        bus.io_m_rd  = 3'b000;
        @(negedge clock);
        bus.io_m_wr = '0;
        bus.io_m_wdata[0 +: DW] = $urandom;
        @(negedge clock);
        bus.io_m_wdata[0 +: DW] = $urandom;
        @(negedge clock);
        checks++; if (bus.io_m_wready !== 3'b001) begin errors++; $display("FAIL mid_pre_wready: got %b expected 001", bus.io_m_wready); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.io_busy); end
        checks++; if ((bus.io_m_wready | bus.io_m_grant | bus.io_m_done | bus.io_m_rvalid) !== '0) begin errors++; $display("FAIL mid_outputs: got %b expected 000", bus.io_m_wready | bus.io_m_grant | bus.io_m_done | bus.io_m_rvalid); end
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.io_m_done != '0) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", seen_done); end
        setup(0, 8, 4);
        run_txn(3'b000, 3'b001, 0);
        model_run(3'b000, 3'b001, 0);
        checks++; if (rq[0] != exp_rq[0]) begin errors++; $display("FAIL mid_mem_cleared: got %p expected %p", rq[0], exp_rq[0]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_round_robin();
        test_len0_start();
        test_wr_rd_both();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
